// File: rtl/rom_fetch_ctrl_if.sv
// Fetch-side bundle between rom_fetch_ctrl, the instruction ROM and decode.
// master = the fetch controller; slave = the ROM/decode/branch environment.
interface rom_fetch_ctrl_if;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        InstrReady;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        nrd;
  logic [31:0] Address;
  logic [31:0] RomData;
  logic        Fault;

  modport master (
    input  Redirect, RedirectPC, InstrReady, RomData,
    output InstrValid, Instr, InstrPC, nrd, Address, Fault
  );

  modport slave (
    output Redirect, RedirectPC, InstrReady, RomData,
    input  InstrValid, Instr, InstrPC, nrd, Address, Fault
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch controller: owns fetch PC, strobes the ROM, queues words in a prefetch FIFO.
// Define FETCH_FAULT_EN to build the alignment/range check and the sticky FAULT state.
module rom_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ROM_BYTES  = 100,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic              CLK,
  input logic              Reset,
  rom_fetch_ctrl_if.master bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  if (ROM_BYTES < 4 || FIFO_DEPTH < 2 || FIFO_DEPTH > 8 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_check
    $error("rom_fetch_ctrl: unsupported ROM_BYTES/FIFO_DEPTH");
  end

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem   [FIFO_DEPTH];

  logic head_vld;
  logic pop;
  logic push;
  logic room;
  logic fetch_ok;

  assign head_vld = (count_q != '0);
  assign pop      = head_vld & bus.InstrReady;
  // A pop this cycle frees the slot the push is about to fill.
  assign room     = (count_q < DEPTH_C) | pop;

`ifdef FETCH_FAULT_EN
  typedef enum logic {ST_FETCH, ST_FAULT} state_t;

  localparam logic [31:0] LAST_WORD = 32'(ROM_BYTES - 4);

  state_t state_q;
  logic   fault_q;
  logic   pc_bad;
  logic   redir_bad;
  logic   fault_now;

  assign pc_bad    = (pc_q[1:0] != 2'b00) | (pc_q > LAST_WORD);
  assign redir_bad = (bus.RedirectPC[1:0] != 2'b00) | (bus.RedirectPC > LAST_WORD);
  assign fault_now = !Reset & (state_q == ST_FETCH) & !bus.Redirect & pc_bad;
  assign fetch_ok  = !Reset & (state_q == ST_FETCH) & !pc_bad;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (fault_now) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end
        end
        ST_FAULT: begin
          if (bus.Redirect && !redir_bad) begin
            state_q <= ST_FETCH;
            fault_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // The detecting cycle flags combinationally; the register holds it afterwards.
  assign bus.Fault = fault_q | fault_now;
`else
  assign fetch_ok  = !Reset;
  assign bus.Fault = 1'b0;
`endif

  assign push = fetch_ok & !bus.Redirect & room;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.Redirect) begin
      // Redirect wins: any same-cycle pop is dropped along with the queue.
      pc_d     = bus.RedirectPC;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.RomData;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

  // Head is forced to zero when empty so reset shows clean outputs.
  assign bus.InstrValid = head_vld;
  assign bus.Instr      = head_vld ? data_mem[rd_ptr_q] : 32'h0;
  assign bus.InstrPC    = head_vld ? pc_mem[rd_ptr_q] : 32'h0;
  assign bus.nrd        = !push;
  assign bus.Address    = pc_q;
endmodule

// File: doc/rom_fetch_ctrl.md
# rom_fetch_ctrl

Instruction-fetch controller sitting between the PC/branch logic and the byte-addressed instruction ROM. It owns the fetch PC and drives the ROM's active-low read strobe and address. It captures each big-endian 32-bit word into a small prefetch FIFO and hands instructions to decode over a valid/ready handshake. It also handles branch/jump redirects, including flushing the FIFO, and detects out-of-range or misaligned fetches.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- ROM_BYTES, 100, ROM size in bytes; last legal word address is ROM_BYTES-4
- FIFO_DEPTH, 2, prefetch entries (power of two, 2..8)

- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- Redirect  in  1  load RedirectPC as new fetch PC, flush FIFO
- RedirectPC  in  32  redirect target byte address
- InstrReady  in  1  decode accepts head entry this cycle
- InstrValid  out  1  head entry valid
- Instr  out  32  head instruction word
- InstrPC  out  32  byte address of head instruction
- nrd  out  1  ROM read strobe, active low
- Address  out  32  ROM byte address (= fetch PC)
- RomData  in  32  ROM read data, combinational from nrd/Address
- Fault  out  1  fetch fault flag (sticky)

## Operation
- States: FETCH, FAULT. Reset enters FETCH.
- pop = InstrValid & InstrReady.
- push = (state==FETCH) & !Redirect & (count<FIFO_DEPTH | pop).
- nrd = !push. Address = fetch PC at all times.
- On push: {RomData, fetch PC} is written to the FIFO tail, and fetch PC += 4 (32-bit wrap).
- Push and pop in the same cycle: count is unchanged, giving full throughput of 1 instruction/cycle.
- Redirect has priority over push and pop:
  - FIFO count goes to 0 and fetch PC is loaded with RedirectPC.
  - Any pop in that cycle is discarded; decode must treat it as not taken.
- Fault check in FETCH: if fetch PC[1:0]!=0 or fetch PC > ROM_BYTES-4, go to FAULT instead of pushing.
  - nrd=1 and Fault=1 in that same cycle (combinational); Fault is registered thereafter.
- In FAULT:
  - No pushes; existing FIFO entries still drain normally.
  - Redirect to an aligned, in-range address returns to FETCH and clears Fault.
  - A bad redirect target stays in FAULT.
- Instr/InstrPC are the FIFO head; they are don't-care while InstrValid=0.

## Timing
- Reset values: InstrValid=0, Instr=0, InstrPC=0, nrd=1 (while Reset high), Address=RESET_PC, Fault=0, count=0, state=FETCH.
- Reset mid-operation: outputs take reset values immediately, without waiting for a clock edge. FIFO contents are lost.
- First fetch occurs in the first cycle with Reset low. That word appears with InstrValid=1 in the next cycle.
- Latency: fetch in cycle N means InstrValid in cycle N+1.
- After Redirect in cycle N: fetch from RedirectPC in N+1, InstrValid in N+2.
- Full FIFO with InstrReady=0: nrd=1, fetch PC held, no word lost or duplicated.
- Empty FIFO: InstrValid=0; InstrReady is ignored.

## Configuration
- FETCH_FAULT_EN: when defined, the range/alignment check and FAULT state are built as above.
- When not defined:
  - Fault is tied to 0 and the FAULT state is absent.
  - Fetch proceeds at any address and the low two PC bits are passed through unchanged.
  - The ROM returns whatever it holds; out-of-range behaviour is the ROM's.

## Test plan
- Reset, then InstrReady=1 constantly, ROM bytes 00..0F: accepted stream is InstrPC 0,4,8,12 with Instr 00010203, 04050607, …. InstrValid first rises in cycle 1 after reset release.
- Backpressure: InstrReady=0 for 5 cycles from start.
  - count reaches 2 (PC 0,4) and nrd=1 with Address=8 thereafter.
  - On InstrReady=1, the stream resumes 0,4,8 with no gaps or duplicates.
- Redirect to 0x20 while FIFO is full and InstrReady=1: that cycle's pop is discarded. Next cycle InstrValid=0 and Address=0x20; the cycle after, InstrPC=0x20.
- Sequential run with ROM_BYTES=100 (FETCH_FAULT_EN defined):
  - PC 96 is fetched normally.
  - At PC 100, Fault=1 and nrd=1; entries before it drain, then InstrValid=0.
  - Redirect to 0x0 clears Fault.
- Redirect to 0x22 (FETCH_FAULT_EN defined) gives Fault=1 with no push. Redirect to 0x24 gives Fault=0 and InstrPC=0x24 two cycles later.
- Assert Reset asynchronously mid-stream with 2 entries queued: InstrValid=0, nrd=1, Address=RESET_PC before the next edge. Fetch restarts at RESET_PC after release.
